sky130_gpio_pad_ctrl: RTL and testbench

Core-side controller for one sky130 GPIOv2 pad: it drives the pad's control inputs (OUT, OE_N, DM, INP_DIS, SLOW, VTRIP_SEL, IB_MODE_SEL) from a small register file and receives the pad's IN signal. The incoming signal passes through a 2-flop synchronizer and a programmable glitch filter, then through rise/fall edge detection with sticky flags and a level interrupt. One instance sits in the core-side padring glue per GPIO, between the bus fabric and the GPIO pad cell.

---
 rtl/sky130_gpio_pad_ctrl.sv | 132 +++++++++++++
 tb/tb_sky130_gpio_pad_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sky130_gpio_pad_ctrl.sv
// Core-side controller for one sky130 GPIOv2 pad: control register file, input synchronizer,
// glitch filter (enabled by GPIO_PAD_CTRL_FILTER_EN), edge flags and level interrupt.
module sky130_gpio_pad_ctrl #(
  parameter int DW     = 16,
  parameter int FILT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          irq,
  input  logic          pad_in,
  output logic          pad_out,
  output logic          pad_oe_n,
  output logic          pad_inp_dis,
  output logic [2:0]    pad_dm,
  output logic          pad_slow,
  output logic          pad_vtrip_sel,
  output logic          pad_ib_mode_sel
);

  localparam logic [8:0] CTRL_RST = 9'h008;  // dm = 3'b001, everything else off

  logic [8:0]    ctrl_q, ctrl_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic          rise_q, rise_d, fall_q, fall_d;
  logic [1:0]    irq_en_q, irq_en_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          wr_ctrl, wr_stat, wr_irqen;
  logic          unused_wdata;

`ifdef GPIO_PAD_CTRL_FILTER_EN
  logic [FILT_W-1:0] cnt_q, cnt_d, filt_len_q, filt_len_d;
  logic              wr_filt;
`endif

  assign unused_wdata = ^wdata;

  always_comb begin
    wr_ctrl  = wr_en && (addr == 2'd0);
    wr_stat  = wr_en && (addr == 2'd1);
    wr_irqen = wr_en && (addr == 2'd2);
    ctrl_d   = wr_ctrl  ? wdata[8:0] : ctrl_q;
    irq_en_d = wr_irqen ? wdata[1:0] : irq_en_q;
    sync1_d  = pad_in;
    sync2_d  = sync1_q;

`ifdef GPIO_PAD_CTRL_FILTER_EN
    wr_filt    = wr_en && (addr == 2'd3);
    filt_len_d = wr_filt ? wdata[FILT_W-1:0] : filt_len_q;
    filt_d     = filt_q;
    cnt_d      = cnt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == filt_len_q) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + FILT_W'(1);
    end
`else
    filt_d = sync2_q;
`endif

    // A new edge event beats a W1C hitting the same flag.
    rise_d = (filt_d & ~filt_q) | (rise_q & ~(wr_stat & wdata[1]));
    fall_d = (~filt_d & filt_q) | (fall_q & ~(wr_stat & wdata[2]));

    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        2'd0:    rdata_d = DW'(ctrl_q);
        2'd1:    rdata_d = DW'({fall_q, rise_q, filt_q});
        2'd2:    rdata_d = DW'(irq_en_q);
`ifdef GPIO_PAD_CTRL_FILTER_EN
        default: rdata_d = DW'(filt_len_q);
`else
        default: rdata_d = '0;
`endif
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= CTRL_RST;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      filt_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      irq_en_q <= '0;
      rdata_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      filt_q   <= filt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef GPIO_PAD_CTRL_FILTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      filt_len_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      filt_len_q <= filt_len_d;
    end
  end
`endif

  assign pad_out         = ctrl_q[0];
  assign pad_oe_n        = ~ctrl_q[1];
  assign pad_inp_dis     = ~ctrl_q[2];
  assign pad_dm          = ctrl_q[5:3];
  assign pad_slow        = ctrl_q[6];
  assign pad_vtrip_sel   = ctrl_q[7];
  assign pad_ib_mode_sel = ctrl_q[8];
  assign rdata           = rdata_q;
  assign irq             = (rise_q & irq_en_q[0]) | (fall_q & irq_en_q[1]);

endmodule

// File: tb/tb_sky130_gpio_pad_ctrl.sv
// Directed bench for sky130_gpio_pad_ctrl; filter cases follow GPIO_PAD_CTRL_FILTER_EN.
module tb_sky130_gpio_pad_ctrl;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [1:0]    addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          irq, pad_in = 1'b0;
  logic          pad_out, pad_oe_n, pad_inp_dis, pad_slow, pad_vtrip_sel, pad_ib_mode_sel;
  logic [2:0]    pad_dm;
  logic [DW-1:0] d;
  int            nchk = 0, nerr = 0;

  sky130_gpio_pad_ctrl #(.DW(DW), .FILT_W(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irq(irq), .pad_in(pad_in),
    .pad_out(pad_out), .pad_oe_n(pad_oe_n), .pad_inp_dis(pad_inp_dis),
    .pad_dm(pad_dm), .pad_slow(pad_slow), .pad_vtrip_sel(pad_vtrip_sel),
    .pad_ib_mode_sel(pad_ib_mode_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    wr_en = 1'b1; addr = a; wdata = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [DW-1:0] v);
    @(negedge clk);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    v = rdata;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_oe_n", pad_oe_n, 1);
    chk("rst_inp_dis", pad_inp_dis, 1);
    chk("rst_dm", pad_dm, 3'b001);
    chk("rst_out", pad_out, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;

    // output drive
    wr(2'd0, 16'h00F3);
    chk("drv_out", pad_out, 1);
    chk("drv_oe_n", pad_oe_n, 0);
    chk("drv_inp_dis", pad_inp_dis, 1);
    chk("drv_dm", pad_dm, 3'b110);
    chk("drv_slow", pad_slow, 1);
    chk("drv_vtrip", pad_vtrip_sel, 1);
    chk("drv_ib", pad_ib_mode_sel, 0);
    rd(2'd0, d); chk("rd_ctrl", d, 16'h00F3);
    wr(2'd0, 16'hFFFF);
    rd(2'd0, d); chk("rd_ctrl_mask", d, 16'h01FF);
    chk("drv_ib_on", pad_ib_mode_sel, 1);
    wr(2'd2, 16'hFFFF);
    rd(2'd2, d); chk("rd_irqen_mask", d, 16'h0003);

    // asynchronous mid-cycle reset
    @(negedge clk); #2 reset = 1'b1; #1;
    chk("arst_oe_n", pad_oe_n, 1);
    chk("arst_inp_dis", pad_inp_dis, 1);
    chk("arst_dm", pad_dm, 3'b001);
    chk("arst_irq", irq, 0);
    chk("arst_rdata", rdata, 0);
    @(negedge clk); reset = 1'b0;
    rd(2'd2, d); chk("arst_irqen", d, 0);

    // rise edge, no filtering
    wr(2'd2, 16'h0001);
    pad_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("rise_e1_irq", irq, 0);
    @(negedge clk);
    chk("rise_e2_irq", irq, 1);
    rd(2'd1, d); chk("rise_status", d, 16'h0003);
    wr(2'd1, 16'h0002);
    chk("rise_w1c_irq", irq, 0);
    rd(2'd1, d); chk("rise_cleared", d, 16'h0001);

    // fall edge
    wr(2'd2, 16'h0003);
    pad_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("fall_irq", irq, 1);
    rd(2'd1, d); chk("fall_status", d, 16'h0004);
    wr(2'd1, 16'h0004);
    rd(2'd1, d); chk("fall_cleared", d, 16'h0000);

    // W1C of fall colliding with a fresh fall event
    pad_in = 1'b1;
    repeat (3) @(negedge clk);
    wr(2'd1, 16'h0002);
    rd(2'd1, d); chk("coll_pre", d, 16'h0001);
    pad_in = 1'b0;
    repeat (2) @(negedge clk);
    wr_en = 1'b1; addr = 2'd1; wdata = 16'h0004;
    @(negedge clk);
    wr_en = 1'b0;
    chk("coll_irq", irq, 1);
    rd(2'd1, d); chk("coll_status", d, 16'h0004);

    // read and write the same address together: read sees pre-write value
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b1; addr = 2'd1; wdata = 16'h0004;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    chk("rdwr_pre", rdata, 16'h0004);
    rd(2'd1, d); chk("rdwr_post", d, 16'h0000);

`ifdef GPIO_PAD_CTRL_FILTER_EN
    wr(2'd3, 16'h0004);
    rd(2'd3, d); chk("filt_len_rd", d, 16'h0004);
    // 4-cycle pulse is rejected
    pad_in = 1'b1;
    repeat (4) @(negedge clk);
    pad_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch4_irq", irq, 0);
    rd(2'd1, d); chk("glitch4_status", d, 16'h0000);
    // 5-cycle pulse passes: rise at E+6, fall after release
    pad_in = 1'b1;
    repeat (5) @(negedge clk);
    pad_in = 1'b0;
    @(negedge clk);
    chk("pulse5_e5_irq", irq, 0);
    @(negedge clk);
    chk("pulse5_e6_irq", irq, 1);
    rd(2'd1, d); chk("pulse5_rise", d, 16'h0003);
    repeat (10) @(negedge clk);
    rd(2'd1, d); chk("pulse5_fall", d, 16'h0006);
`else
    wr(2'd3, 16'h00FF);
    rd(2'd3, d); chk("filt_rd_zero", d, 16'h0000);
    // single-cycle pulse captured as rise then fall
    pad_in = 1'b1;
    @(negedge clk);
    pad_in = 1'b0;
    repeat (6) @(negedge clk);
    chk("pulse1_irq", irq, 1);
    rd(2'd1, d); chk("pulse1_status", d, 16'h0006);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
